// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared store-size codes, default base address and byte-lane mask helper
// for the ysyx_23060180 memory responder.
package ysyx_23060180_mem_pkg;

    localparam logic [3:0]  SZ_BYTE = 4'd1;
    localparam logic [3:0]  SZ_HALF = 4'd2;
    localparam logic [3:0]  SZ_WORD = 4'd4;

    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h8000_0000;

    // Byte-enable mask for a store of `size` bytes at byte offset `off`;
    // 0 flags an illegal size or a store that would spill past the word.
    function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] off);
        logic [3:0] base;
        logic [7:0] shifted;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            SZ_WORD: base = 4'b1111;
            default: base = 4'b0000;
        endcase
        shifted = {4'b0000, base} << off;
        lane_mask = (shifted[7:4] != 4'b0000) ? 4'b0000 : shifted[3:0];
    endfunction

endpackage

// File: rtl/ysyx_23060180_bytelane_ram.sv
// Word-organised RAM split into four byte lanes, each with its own write
// enable and a registered read that returns pre-write contents.
module ysyx_23060180_bytelane_ram #(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_array [DEPTH_WORDS];
            logic [7:0] lane_rd_q;

            // Read and write share the edge, so the read sees the old byte.
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    lane_rd_q <= lane_array[addr];
                end
                if (we[gi]) begin
                    lane_array[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/ysyx_23060180_mem_resp.sv
// Slave end of the core's mem_* bus: address decode, store lane steering,
// read alignment shift. Optional sticky fault reporting: YSYX_23060180_MEM_FAULT_EN.
module ysyx_23060180_mem_resp
    import ysyx_23060180_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int          DEPTH_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wbit_en,
    output logic [31:0] mem_rdata
`ifdef YSYX_23060180_MEM_FAULT_EN
    ,
    output logic        mem_fault,
    output logic [31:0] mem_fault_addr
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [1:0]    off;
    logic [29:0]   rel_word;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [3:0]    wr_mask;
    logic          wr_ok;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [1:0]    off_q, off_d;
    logic          hit_q, hit_d;

    assign off      = mem_raddr[1:0];
    assign rel_word = 30'((mem_raddr - ADDR_BASE) >> 2);
    assign in_range = (mem_raddr >= ADDR_BASE) && ({2'b00, rel_word} < 32'(DEPTH_WORDS));
    assign idx      = rel_word[AW-1:0];

    assign wr_mask   = lane_mask(mem_wbit_en, off);
    assign wr_ok     = mem_wr && in_range && (wr_mask != 4'b0000);
    // A store coinciding with an asserted reset must not reach the array.
    assign ram_we    = (wr_ok && rstn_in) ? wr_mask : 4'b0000;
    assign ram_wdata = mem_wdata << {off, 3'b000};

    ysyx_23060180_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .rd_en (mem_rd && in_range),
        .we    (ram_we),
        .addr  (idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // hit_q remembers whether the last read hit the array; a miss or reset reads as 0.
    always_comb begin
        off_d = off_q;
        hit_d = hit_q;
        if (mem_rd) begin
            off_d = off;
            hit_d = in_range;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            off_q <= 2'b00;
            hit_q <= 1'b0;
        end else begin
            off_q <= off_d;
            hit_q <= hit_d;
        end
    end

    assign mem_rdata = hit_q ? (ram_rdata >> {off_q, 3'b000}) : 32'h0;

`ifdef YSYX_23060180_MEM_FAULT_EN
    logic        fault_event;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    assign fault_event = (mem_rd && !in_range) || (mem_wr && !wr_ok);

    always_comb begin
        fault_d      = fault_q | fault_event;
        fault_addr_d = fault_addr_q;
        if (fault_event && !fault_q) begin
            fault_addr_d = mem_raddr;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign mem_fault      = fault_q;
    assign mem_fault_addr = fault_addr_q;
`endif

endmodule

// File: tb/tb_ysyx_23060180_mem_resp.sv
// Scoreboard bench for ysyx_23060180_mem_resp: a byte-level reference model
// queues the expected bus state per cycle; an independent monitor compares.
module tb_ysyx_23060180_mem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_raddr, mem_wdata;
    logic [3:0]  mem_wbit_en;
    logic [31:0] mem_rdata;
`ifdef YSYX_23060180_MEM_FAULT_EN
    logic        mem_fault;
    logic [31:0] mem_fault_addr;
`endif

    always #5 clk = ~clk;

    ysyx_23060180_mem_resp dut (
        .clk            (clk),
        .rstn_in        (rstn_in),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_raddr      (mem_raddr),
        .mem_wdata      (mem_wdata),
        .mem_wbit_en    (mem_wbit_en),
        .mem_rdata      (mem_rdata)
`ifdef YSYX_23060180_MEM_FAULT_EN
        ,
        .mem_fault      (mem_fault),
        .mem_fault_addr (mem_fault_addr)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] faddr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int unsigned];
    logic [31:0] m_rdata;
    logic        m_fault;
    logic [31:0] m_faddr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h0001_0000);
    endfunction

    // Drive one bus cycle at a negedge, record the expected post-edge state,
    // then advance to the next negedge.
    task automatic op(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sz);
        int          off;
        int          n;
        int unsigned wi;
        bit          ok, legal, wr_good, bad;
        logic [31:0] w;
        exp_t        e;
        mem_rd = rd; mem_wr = wr; mem_raddr = addr; mem_wdata = wdata; mem_wbit_en = sz;
        off   = int'(addr[1:0]);
        n     = int'(sz);
        ok    = in_rng(addr);
        wi    = (addr - BASE) >> 2;
        legal = (n == 1) || (n == 2) || (n == 4);
        w     = (ok && model_mem.exists(wi)) ? model_mem[wi] : 32'h0;
        if (rd) m_rdata = ok ? (w >> (8 * off)) : 32'h0;
        wr_good = wr && ok && legal && (off + n <= 4);
        if (wr_good) begin
            for (int b = 0; b < n; b++) w[8*(off+b) +: 8] = wdata[8*b +: 8];
            model_mem[wi] = w;
        end
        bad = (rd && !ok) || (wr && !wr_good);
        if (bad && !m_fault) m_faddr = addr;
        if (bad) m_fault = 1'b1;
        e.rdata = m_rdata; e.fault = m_fault; e.faddr = m_faddr;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    endtask

    // Monitor: every active edge out of reset has exactly one expectation.
    initial begin
        exp_t e;
        int   txn = 0;
        forever begin
            @(posedge clk);
            if (rstn_in) begin
                #1;
                txn++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_underflow: got none, expected entry at txn %0d", txn);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d rdata=%h (expected %h) fault=%0b", txn, mem_rdata, e.rdata, e.fault);
                    check("rdata", mem_rdata, e.rdata);
`ifdef YSYX_23060180_MEM_FAULT_EN
                    check("fault", {31'h0, mem_fault}, {31'h0, e.fault});
                    check("fault_addr", mem_fault_addr, e.faddr);
`endif
                end
            end
        end
    end

    initial begin
        logic [3:0]  sizes [8];
        logic [31:0] oor   [4];
        logic [31:0] a;
        sizes[0] = 4'd1; sizes[1] = 4'd2; sizes[2] = 4'd4; sizes[3] = 4'd0;
        sizes[4] = 4'd3; sizes[5] = 4'd4; sizes[6] = 4'd1; sizes[7] = 4'd8;
        oor[0] = 32'h7FFF_FFFC; oor[1] = 32'h8001_0000; oor[2] = 32'h0000_0000; oor[3] = 32'hFFFF_FFF0;

        rstn_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_raddr = BASE; mem_wdata = 32'h0; mem_wbit_en = 4'd0;
        m_rdata = 32'h0; m_fault = 1'b0; m_faddr = 32'h0;
        #1;
        check("reset_rdata", mem_rdata, 32'h0);
`ifdef YSYX_23060180_MEM_FAULT_EN
        check("reset_fault", {31'h0, mem_fault}, 32'h0);
        check("reset_fault_addr", mem_fault_addr, 32'h0);
`endif
        mem_rd = 1'b1;
        repeat (2) @(negedge clk);
        check("rdata_during_reset", mem_rdata, 32'h0);
        rstn_in = 1'b1;
        idle();

        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'd4);

        op(1'b0, 1'b1, BASE, 32'h0010_0073, 4'd4);
        op(1'b1, 1'b0, BASE, 32'h0, 4'd0);
        op(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'd4);
        op(1'b0, 1'b1, BASE + 32'h12, 32'h0000_005A, 4'd1);
        op(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'd0);
        op(1'b1, 1'b0, BASE + 32'h12, 32'h0, 4'd0);
        op(1'b0, 1'b1, BASE + 32'h13, 32'h0000_1234, 4'd2);
        op(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'd0);
        op(1'b0, 1'b1, BASE + 32'h20, 32'h1111_1111, 4'd4);
        op(1'b1, 1'b1, BASE + 32'h20, 32'h2222_2222, 4'd4);
        op(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'd0);
        op(1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'd0);
        op(1'b1, 1'b0, 32'h8001_0000, 32'h0, 4'd0);
        op(1'b0, 1'b1, BASE + 32'hFFFC, 32'hCAFE_F00D, 4'd4);
        op(1'b1, 1'b0, BASE + 32'hFFFC, 32'h0, 4'd0);
        op(1'b1, 1'b0, BASE + 32'hFFFE, 32'h0, 4'd0);
        op(1'b0, 1'b1, BASE + 32'h30, 32'hFFFF_FFFF, 4'd0);
        op(1'b0, 1'b1, BASE + 32'h30, 32'hFFFF_FFFF, 4'd3);
        op(1'b1, 1'b0, BASE + 32'h30, 32'h0, 4'd0);
        op(1'b0, 1'b1, BASE + 32'h04, 32'h0404_0404, 4'd4);
        op(1'b0, 1'b1, BASE + 32'h08, 32'h0808_0808, 4'd4);
        op(1'b1, 1'b0, BASE, 32'h0, 4'd0);
        op(1'b1, 1'b0, BASE + 32'h04, 32'h0, 4'd0);
        op(1'b1, 1'b0, BASE + 32'h08, 32'h0, 4'd0);
        idle();
        idle();

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? oor[$urandom_range(0, 3)]
                                             : BASE + 32'($urandom_range(0, 255));
            op(1'($urandom), 1'($urandom), a, $urandom, sizes[$urandom_range(0, 7)]);
        end

        // Asynchronous reset in the middle of a read+write cycle.
        op(1'b0, 1'b1, BASE + 32'h40, 32'hA5A5_5A5A, 4'd4);
        op(1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'd0);
        mem_rd = 1'b1; mem_wr = 1'b1; mem_raddr = BASE + 32'h40;
        mem_wdata = 32'h1234_5678; mem_wbit_en = 4'd4;
        rstn_in = 1'b0;
        #1;
        check("async_clear_rdata", mem_rdata, 32'h0);
`ifdef YSYX_23060180_MEM_FAULT_EN
        check("async_clear_fault", {31'h0, mem_fault}, 32'h0);
        check("async_clear_fault_addr", mem_fault_addr, 32'h0);
`endif
        m_rdata = 32'h0; m_fault = 1'b0; m_faddr = 32'h0;
        @(negedge clk);
        rstn_in = 1'b1;
        op(1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'd0);
        op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'd0);
        idle();

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_mem_resp.md
# ysyx_23060180_mem_resp

Single-port synchronous memory responder: the slave end of the core's `mem_*` bus. It holds program and data in a word-organised array. Reads return data one cycle after `mem_rd`, shifted right so that the addressed byte sits in bits [7:0]. Writes are size-coded stores (1/2/4 bytes) steered onto byte lanes.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h8000_0000: byte address of array word 0.
- `DEPTH_WORDS`, default 16384: array depth in 32-bit words (64 KiB). Must be a power of two.

Ports:
- `clk`, in, 1: clock.
- `rstn_in`, in, 1: reset, asynchronous, active-low.
- `mem_rd`, in, 1: read request, sampled at posedge.
- `mem_wr`, in, 1: write request, sampled at posedge.
- `mem_raddr`, in, 32: byte address shared by read and write.
- `mem_wdata`, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `mem_wbit_en`, in, 4: store size as a byte count: 1 = byte, 2 = half, 4 = word. Any other value means no write.
- `mem_rdata`, out, 32: registered read data.
- `mem_fault`, out, 1: sticky access fault. Present only with the macro below.
- `mem_fault_addr`, out, 32: address of the first fault. Present only with the macro below.

## Operation
- Address decode:
  - `off` = `mem_raddr[1:0]`
  - `idx` = (`mem_raddr` − `ADDR_BASE`) >> 2
  - An address is in range when `mem_raddr` ≥ `ADDR_BASE` and `idx` < `DEPTH_WORDS`. The subtraction is unsigned 32-bit.
- Read, when `mem_rd` is high at an edge:
  - `mem_rdata` ← word[`idx`] >> (8·`off`), with upper bytes zero-filled.
  - An out-of-range read gives `mem_rdata` ← 0.
  - Read size is unknown to the responder, so reads never fault on alignment.
- Write, when `mem_wr` is high at an edge and `mem_wbit_en` ∈ {1, 2, 4}:
  - Byte mask = ((1 << n) − 1) << `off`.
  - Lane data = `mem_wdata` << (8·`off`).
  - Only the masked bytes of word[`idx`] are updated.
- A write is dropped (array unchanged) when any of these hold:
  - `off` + n > 4 (misaligned);
  - the address is out of range;
  - `mem_wbit_en` is an illegal size.
- `mem_rd` and `mem_wr` in the same cycle: read-before-write. `mem_rdata` returns the pre-write contents and the write is still performed.
- No request: `mem_rdata` holds its last value.
- The array is not reset.

## Timing
- Read latency is exactly 1 cycle. The core samples `mem_rdata` in the cycle after it asserts `mem_rd`.
- Back-to-back reads on consecutive cycles are supported, one result per cycle.
- A write is visible to a read issued on the next cycle or later.
- There is no handshake or backpressure; every request completes in one cycle.
- Reset values: `mem_rdata` = 0, `mem_fault` = 0, `mem_fault_addr` = 0.
- Reset asserted mid-access: `mem_rdata` clears immediately (asynchronous). Any write on that edge is not performed.

## Configuration
- Macro: `YSYX_23060180_MEM_FAULT_EN`.
- Defined:
  - `mem_fault` is set one cycle after any out-of-range read or write, misaligned write, or write with an illegal size (including `mem_wr` with size 0).
  - On the first such event, `mem_fault_addr` captures `mem_raddr`. Later faults do not overwrite it.
  - Both are cleared only by reset.
  - Access behaviour is otherwise identical to the undefined case.
- Undefined: the fault ports and registers do not exist. Faulting accesses are silently dropped or read as 0.

## Structure
- Package `ysyx_23060180_mem_pkg`:
  - `SZ_BYTE` = 4'd1, `SZ_HALF` = 4'd2, `SZ_WORD` = 4'd4.
  - Default `ADDR_BASE`.
  - Function `lane_mask(size, off)` returning the 4-bit byte mask, with 0 meaning illegal.
- Sub-module `ysyx_23060180_bytelane_ram`: `DEPTH_WORDS` × 32 array with four byte write enables and a registered read port, read-before-write.
- The top level holds address decode, lane steering, read shift, and fault logic.

## Test plan
- Reset, then read 0x8000_0000 after preloading word 0 = 0x0010_0073 → `mem_rdata` = 0x0010_0073 on the next cycle; it was 0 during reset.
- Store word 0xDEADBEEF at 0x8000_0010, then a byte store of 0x5A at 0x8000_0012 → reading 0x8000_0010 returns 0xDE5ABEEF. Reading 0x8000_0012 returns 0x0000DE5A.
- Store half 0x1234 at 0x8000_0013 (misaligned) → word unchanged; with the macro, `mem_fault` = 1 and `mem_fault_addr` = 0x8000_0013.
- `mem_rd` and `mem_wr` together at 0x8000_0020 (old 0x1111_1111, new word 0x2222_2222) → `mem_rdata` = 0x1111_1111; the next read gives 0x2222_2222.
- Read 0x7FFF_FFFC and 0x8001_0000 (out of range) → `mem_rdata` = 0. The first fault address is retained; a second fault leaves it unchanged.
- Back-to-back reads of 0x8000_0000, 0x8000_0004, 0x8000_0008 → three consecutive results, each exactly 1 cycle after its request.
